// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core and debug/loader share one memory port.
// Grants are decided combinationally each cycle; read responses return one cycle later.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  c_req_i,
  input  logic                  c_we_i,
  input  logic [1:0]            c_size_i,
  input  logic [ADDR_WIDTH-1:0] c_addr_i,
  input  logic [DATA_WIDTH-1:0] c_wdata_i,
  output logic                  c_gnt_o,
  output logic                  c_stall_o,
  output logic                  c_rvalid_o,
  output logic [DATA_WIDTH-1:0] c_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [1:0]            d_size_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  input  logic                  d_lock_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  m_en_o,
  output logic                  m_we_o,
  output logic [1:0]            m_size_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [DATA_WIDTH-1:0] m_wdata_o,
  input  logic [DATA_WIDTH-1:0] m_rdata_i
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_CNT = HW'(MAX_HOLD);
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          c_rvalid_q, d_rvalid_q;
  logic          c_win_s, d_win_s;

  // Grant decision; a locked debug burst may keep the port until hold_cnt saturates.
  always_comb begin
    c_win_s = 1'b0;
    d_win_s = 1'b0;
    if (!rst_ni) begin
      c_win_s = 1'b0;
      d_win_s = 1'b0;
    end else if (c_req_i && d_req_i) begin
      if (owner_q == OWN_DBG && d_lock_i && hold_cnt_q < MAX_CNT) begin
        d_win_s = 1'b1;
      end else if (last_q == PORT_DBG) begin
        c_win_s = 1'b1;
      end else begin
        d_win_s = 1'b1;
      end
    end else if (c_req_i) begin
      c_win_s = 1'b1;
    end else if (d_req_i) begin
      d_win_s = 1'b1;
    end else begin
      c_win_s = 1'b0;
      d_win_s = 1'b0;
    end
  end

  // Memory request mux: the granted port's payload passes straight through.
  always_comb begin
    m_en_o    = 1'b0;
    m_we_o    = 1'b0;
    m_size_o  = 2'b00;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (c_win_s) begin
      m_en_o    = 1'b1;
      m_we_o    = c_we_i;
      m_size_o  = c_size_i;
      m_addr_o  = c_addr_i;
      m_wdata_o = c_wdata_i;
    end else if (d_win_s) begin
      m_en_o    = 1'b1;
      m_we_o    = d_we_i;
      m_size_o  = d_size_i;
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
    end else begin
      m_en_o = 1'b0;
    end
  end

  assign c_gnt_o    = c_win_s;
  assign d_gnt_o    = d_win_s;
  assign c_stall_o  = c_req_i & ~c_win_s;
  assign c_rvalid_o = c_rvalid_q;
  assign d_rvalid_o = d_rvalid_q;
  assign c_rdata_o  = c_rvalid_q ? m_rdata_i : '0;
  assign d_rdata_o  = d_rvalid_q ? m_rdata_i : '0;

  // Next-state for ownership history and the locked-burst counter.
  always_comb begin
    owner_d    = OWN_IDLE;
    last_d     = last_q;
    hold_cnt_d = '0;
    if (c_win_s) begin
      owner_d = OWN_CORE;
      last_d  = PORT_CORE;
    end else if (d_win_s) begin
      owner_d = OWN_DBG;
      last_d  = PORT_DBG;
      if (d_lock_i) begin
        hold_cnt_d = (hold_cnt_q == MAX_CNT) ? hold_cnt_q : hold_cnt_q + HW'(1);
      end else begin
        hold_cnt_d = '0;
      end
    end else begin
      owner_d = OWN_IDLE;
    end
  end

  // State registers; each granted read schedules exactly one rvalid on its own port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q    <= OWN_IDLE;
      last_q     <= PORT_DBG;
      hold_cnt_q <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      c_rvalid_q <= c_win_s & ~c_we_i;
      d_rvalid_q <= d_win_s & ~d_we_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a per-cycle reference model plus literal scenario checks.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [1:0] c_size = 2'b00, d_size = 2'b00;
  logic [AW-1:0] c_addr = '0, d_addr = '0;
  logic [DW-1:0] c_wdata = '0, d_wdata = '0, m_rdata = '0;
  logic c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [1:0] m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, c_rdata, d_rdata;

  int n_tests = 0;
  int n_fail = 0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .c_req_i(c_req), .c_we_i(c_we), .c_size_i(c_size), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_gnt_o(c_gnt), .c_stall_o(c_stall), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_size_i(d_size), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_lock_i(d_lock), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .m_en_o(m_en), .m_we_o(m_we), .m_size_o(m_size), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  // Reference model: winner index (-1 none, 0 core, 1 debug), previous owner,
  // last winner, locked-run length and the port whose read returns this cycle.
  int mdl_last = 1;
  int mdl_owner = -1;
  int mdl_run = 0;
  int mdl_rv = -1;
  int win;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [1:0] e_size;
  logic e_we;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctrl", 32'({c_gnt, d_gnt, c_stall, c_rvalid, d_rvalid, m_en, m_we, m_size}), 32'd0);
      chk("rst_addr", m_addr, 32'd0);
      chk("rst_wdata", m_wdata, 32'd0);
      chk("rst_rdata", c_rdata | d_rdata, 32'd0);
      mdl_last = 1; mdl_owner = -1; mdl_run = 0; mdl_rv = -1;
    end else begin
      win = -1;
      if (c_req && d_req) begin
        if (mdl_owner == 1 && d_lock && mdl_run < MAX_HOLD) win = 1;
        else win = (mdl_last == 1) ? 0 : 1;
      end else if (c_req) win = 0;
      else if (d_req) win = 1;
      e_we = 1'b0; e_size = 2'b00; e_addr = '0; e_wdata = '0;
      if (win == 0) begin e_we = c_we; e_size = c_size; e_addr = c_addr; e_wdata = c_wdata; end
      if (win == 1) begin e_we = d_we; e_size = d_size; e_addr = d_addr; e_wdata = d_wdata; end
      chk("c_gnt", 32'(c_gnt), 32'(win == 0));
      chk("d_gnt", 32'(d_gnt), 32'(win == 1));
      chk("c_stall", 32'(c_stall), 32'(c_req && win != 0));
      chk("m_en", 32'(m_en), 32'(win >= 0));
      chk("m_we", 32'(m_we), 32'(e_we));
      chk("m_size", 32'(m_size), 32'(e_size));
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
      chk("c_rvalid", 32'(c_rvalid), 32'(mdl_rv == 0));
      chk("d_rvalid", 32'(d_rvalid), 32'(mdl_rv == 1));
      chk("c_rdata", c_rdata, (mdl_rv == 0) ? m_rdata : 32'd0);
      chk("d_rdata", d_rdata, (mdl_rv == 1) ? m_rdata : 32'd0);
      if (win >= 0) mdl_last = win;
      mdl_owner = win;
      if (win == 1 && d_lock) mdl_run = (mdl_run < MAX_HOLD) ? mdl_run + 1 : MAX_HOLD;
      else mdl_run = 0;
      if (win == 0 && !c_we) mdl_rv = 0;
      else if (win == 1 && !d_we) mdl_rv = 1;
      else mdl_rv = -1;
    end
  end

  task automatic step(input logic cr, input logic cw, input logic [1:0] cs, input logic [31:0] ca,
                      input logic [31:0] cd, input logic dr, input logic dw, input logic [1:0] ds,
                      input logic [31:0] da, input logic [31:0] dd, input logic dl,
                      input logic [31:0] mr);
    @(posedge clk); #1;
    c_req = cr; c_we = cw; c_size = cs; c_addr = ca; c_wdata = cd;
    d_req = dr; d_we = dw; d_size = ds; d_addr = da; d_wdata = dd; d_lock = dl;
    m_rdata = mr;
    @(negedge clk); #1;
  endtask

  task automatic idle(input logic [31:0] mr);
    step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, mr);
  endtask

  task automatic both(input logic lock);
    step(1'b1, 1'b0, 2'b10, 32'h100, 32'd0, 1'b1, 1'b0, 2'b10, 32'h200, 32'd0, lock, 32'h5A);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    c_req = 1'b0; d_req = 1'b0; c_we = 1'b0; d_we = 1'b0; d_lock = 1'b0; m_rdata = 32'hDEAD;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  function automatic string gch();
    return c_gnt ? "C" : (d_gnt ? "D" : "-");
  endfunction

  string seq;
  string stl;

  initial begin
    do_reset();
    idle(32'h0);
    chk("idle_m_en", 32'(m_en), 32'd0);

    // Single core read from idle
    step(1'b1, 1'b0, 2'b10, 32'h4, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'h0);
    chk("rd_gnt", 32'({c_gnt, m_en}), 32'b11);
    chk("rd_addr", m_addr, 32'h4);
    idle(32'h7);
    chk("rd_rvalid", 32'(c_rvalid), 32'd1);
    chk("rd_rdata", c_rdata, 32'h7);

    // Fair alternation after reset
    do_reset();
    seq = ""; stl = "";
    for (int i = 0; i < 4; i++) begin
      both(1'b0);
      seq = {seq, gch()};
      stl = {stl, c_stall ? "1" : "0"};
    end
    chk_s("rr_seq", seq, "CDCD");
    chk_s("rr_stall", stl, "0101");

    // Locked debug burst caps at MAX_HOLD
    idle(32'h0);
    seq = "";
    for (int i = 0; i < 7; i++) begin
      both(1'b1);
      seq = {seq, gch()};
    end
    chk_s("lock_seq", seq, "CDDDDCD");

    // Saturated lock keeps debug when core idle, then yields to core
    idle(32'h0);
    seq = "";
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1, 2'b10, 32'h40, 32'h99, 1'b1, 32'h0);
      seq = {seq, gch()};
    end
    both(1'b1);
    seq = {seq, gch()};
    chk_s("sat_seq", seq, "DDDDDDC");

    // Core byte store
    step(1'b1, 1'b1, 2'b00, 32'h0, 32'h07, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'h0);
    chk("sb_ctrl", 32'({m_we, m_size}), 32'b100);
    chk("sb_wdata", m_wdata, 32'h07);
    idle(32'h33);
    chk("sb_no_rvalid", 32'(c_rvalid), 32'd0);

    // Pipelined reads C then D
    step(1'b1, 1'b0, 2'b10, 32'h0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 2'b10, 32'h8, 32'd0, 1'b0, 32'h11);
    chk("pipe_c", 32'({c_rvalid, d_rvalid}), 32'b10);
    chk("pipe_c_data", c_rdata, 32'h11);
    chk("pipe_d_addr", m_addr, 32'h8);
    idle(32'h22);
    chk("pipe_d", 32'({c_rvalid, d_rvalid}), 32'b01);
    chk("pipe_d_data", d_rdata, 32'h22);

    // Reset right after a granted read drops the response
    step(1'b1, 1'b0, 2'b10, 32'h10, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0; c_req = 1'b0; m_rdata = 32'h77;
    @(negedge clk); #1;
    chk("rst_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_rvalid", 32'(c_rvalid), 32'd0);
    both(1'b0);
    chk_s("post_rst_tie", gch(), "C");
    idle(32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, byte address width; DATA_WIDTH, 32, data width; MAX_HOLD, 4, maximum consecutive locked debug grants while core waits.
REQ-002 The design SHALL have a single clock, and reset SHALL be asynchronous and active-low; ports: clock in 1, system clock; reset in 1, async active-low reset.
REQ-003 Core port: c_req in 1; c_we in 1; c_size in 2 (00 byte, 01 half, 10 word); c_addr in ADDR_WIDTH; c_wdata in DATA_WIDTH; c_gnt out 1; c_stall out 1; c_rvalid out 1; c_rdata out DATA_WIDTH.
REQ-004 Debug/loader port: d_req, d_we, d_size, d_addr, d_wdata, d_gnt, d_rvalid, d_rdata, same widths and meanings as the core port, plus d_lock in 1, which requests back-to-back ownership.
REQ-005 Memory port: m_en out 1; m_we out 1; m_size out 2; m_addr out ADDR_WIDTH; m_wdata out DATA_WIDTH; m_rdata in DATA_WIDTH, valid the cycle after a read with m_en=1.

Function
REQ-006 State register owner in {IDLE, CORE, DBG} SHALL record the port granted in the previous cycle, with IDLE meaning no grant.
REQ-007 Register last SHALL hold the most recently granted port and SHALL persist through IDLE cycles.
REQ-008 hold_cnt SHALL count consecutive DBG grants taken with d_lock=1.
REQ-009 Grant decision SHALL be combinational within the cycle, with no bubble:
- only c_req set: grant core.
- only d_req set: grant debug.
- neither set: no grant.
REQ-010 With c_req and d_req both set:
- grant debug if owner=DBG, d_lock=1 and hold_cnt<MAX_HOLD;
- otherwise grant the port not equal to last (round-robin).
REQ-011 At most one of c_gnt/d_gnt SHALL be 1 in any cycle.
REQ-012 c_gnt=c_req and d_gnt=d_req SHALL hold only when that port is granted.
REQ-013 c_stall SHALL equal c_req & ~c_gnt.
REQ-014 When a port is granted, m_en=1 and m_we/m_size/m_addr/m_wdata SHALL mirror that port's inputs in the same cycle.
REQ-015 With no grant, m_en=0 and m_we=0, and the other m_* outputs SHALL be 0.
REQ-016 Each grant SHALL be exactly one transfer, accepted at the rising edge ending the grant cycle.
REQ-017 A granted read SHALL set a 1-bit pending tag (port id) so that the next cycle asserts that port's rvalid for exactly one cycle.
REQ-018 On the rvalid cycle, that port's rdata SHALL equal m_rdata.
REQ-019 The non-addressed port's rdata SHALL read 0; a granted write SHALL produce no rvalid.
REQ-020 Reads granted in consecutive cycles SHALL pipeline: one rvalid per cycle, in grant order.
REQ-021 hold_cnt SHALL increment, saturating at MAX_HOLD, on each debug grant with d_lock=1.
REQ-022 hold_cnt SHALL clear on any cycle without a debug grant, or on a debug grant with d_lock=0.
REQ-023 When hold_cnt=MAX_HOLD and c_req=1, core SHALL be granted next; if c_req=0, debug SHALL continue to be granted, with the counter held at saturation.
REQ-024 Requests SHALL be level-sensitive: a stalled requester keeps req and payload stable until its gnt is 1; the arbiter SHALL NOT latch payloads.

Reset
REQ-025 While reset=0, the outputs SHALL be: c_gnt, d_gnt, c_stall, c_rvalid, d_rvalid, m_en, m_we = 0; all data/address outputs = 0.
REQ-026 While reset=0, the registers SHALL be: owner=IDLE, last=DBG (core wins the first tie), hold_cnt=0, pending read cleared.
REQ-027 Reset asserted mid-read SHALL discard the pending rvalid; no rvalid pulse SHALL appear after reset deasserts.

Verification
REQ-028 Single core read: c_req=1, c_we=0, c_addr=0x4 from IDLE -> c_gnt=1 and m_en=1 with m_addr=0x4 in that cycle; next cycle c_rvalid=1 with c_rdata=m_rdata (e.g. 0x00000007).
REQ-029 Simultaneous req after reset, d_lock=0, both held 4 cycles -> grants alternate C,D,C,D; c_stall=1 exactly on D cycles.
REQ-030 Debug locked burst, d_lock=1, both requesting, MAX_HOLD=4, owner=DBG -> 4 consecutive d_gnt, then c_gnt on 5th cycle; hold_cnt returns to 0.
REQ-031 Core sb: c_we=1, c_size=00, c_addr=0, c_wdata=0x07 -> m_we=1, m_size=00, m_wdata=0x07 same cycle; no c_rvalid afterwards.
REQ-032 Back-to-back reads C(addr 0) then D(addr 8) -> c_rvalid in cycle 2, d_rvalid in cycle 3, each carrying its own m_rdata.
REQ-033 Reset pulled low the cycle after a granted read -> c_rvalid stays 0 during and after reset; all outputs 0; first tie after release goes to core.
